dvp_transmitter: RTL and testbench

DVP_TRANSMITTER -- requirements
Module: dvp_transmitter

---
 rtl/dvp_pkg.sv | 35 +++
 rtl/dvp_transmitter_if.sv | 12 +
 rtl/dvp_timing_gen.sv | 82 ++++++++
 rtl/dvp_transmitter.sv | 88 ++++++++
 tb/tb_dvp_transmitter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP transmitter/receiver pair: FSM state encoding,
// default video timing and counter sizing helpers.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    HBLANK,
    VFRONT
  } dvp_state_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BACK      = 17;
  localparam int DEF_V_FRONT     = 10;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_transmitter_if.sv
// AXI-stream byte sink feeding the DVP transmitter; tlast marks end of line,
// tuser marks the first byte of a frame.
interface dvp_transmitter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/dvp_timing_gen.sv
// Frame timing sequencer: walks VSYNC/VBACK/ACTIVE/HBLANK/VFRONT with a byte
// counter inside each line period and a line counter inside each span.
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT,
  localparam int BW = cnt_w(H_ACTIVE + H_BLANK),
  localparam int LW = cnt_w(max4(V_ACTIVE, VSYNC_LINES, V_BACK, V_FRONT))
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont,
  output dvp_state_t    state,
  output logic [BW-1:0] byte_cnt,
  output logic [LW-1:0] line_cnt
);

  localparam logic [BW-1:0] BYTE_LAST = BW'(H_ACTIVE + H_BLANK - 1);
  localparam logic [BW-1:0] ACT_LAST  = BW'(H_ACTIVE - 1);

  logic [LW-1:0] span_last;
  dvp_state_t    span_next;
  logic          line_end;
  logic          span_end;

  // HBLANK closes a line of the active span, so it shares the span bookkeeping.
  always_comb begin
    span_last = '0;
    span_next = IDLE;
    case (state)
      VSYNC:   begin span_last = LW'(VSYNC_LINES - 1); span_next = VBACK;  end
      VBACK:   begin span_last = LW'(V_BACK - 1);      span_next = ACTIVE; end
      HBLANK:  begin span_last = LW'(V_ACTIVE - 1);    span_next = VFRONT; end
      VFRONT:  begin span_last = LW'(V_FRONT - 1);     span_next = cont ? VSYNC : IDLE; end
      default: ;
    endcase
  end

  assign line_end = (byte_cnt == BYTE_LAST);
  assign span_end = line_end && (line_cnt == span_last);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      line_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          line_cnt <= '0;
          if (start) state <= VSYNC;
        end
        ACTIVE: begin
          byte_cnt <= byte_cnt + BW'(1);
          if (byte_cnt == ACT_LAST) state <= HBLANK;
        end
        default: begin
          if (!line_end) begin
            byte_cnt <= byte_cnt + BW'(1);
          end else begin
            byte_cnt <= '0;
            if (span_end) begin
              line_cnt <= '0;
              state    <= span_next;
            end else begin
              line_cnt <= line_cnt + LW'(1);
              if (state == HBLANK) state <= ACTIVE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dvp_transmitter.sv
// DVP transmitter: paces an AXI-stream byte source onto href/vsync/dout with
// fixed frame timing, flagging underruns and line/frame marker mismatches.
module dvp_transmitter
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             enable,
  dvp_transmitter_if.slave s,
  output logic [7:0]       dout,
  output logic             href,
  output logic             vsync,
  output logic             underrun,
  output logic             sync_err
);

  localparam int BW = cnt_w(H_ACTIVE + H_BLANK);
  localparam int LW = cnt_w(max4(V_ACTIVE, VSYNC_LINES, V_BACK, V_FRONT));
  localparam logic [BW-1:0] ACT_LAST = BW'(H_ACTIVE - 1);

  dvp_state_t    state;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic          in_active, first_byte, last_byte, err_now, start, cont;
  logic [7:0]    dout_reg;
  logic          href_reg, vsync_reg, underrun_reg, sync_err_reg, err_frame_reg;

  dvp_timing_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .H_BLANK    (H_BLANK),
    .V_ACTIVE   (V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT)
  ) u_timing (
    .pclk    (pclk),
    .rst     (rst),
    .start   (start),
    .cont    (cont),
    .state   (state),
    .byte_cnt(byte_cnt),
    .line_cnt(line_cnt)
  );

  assign in_active  = (state == ACTIVE);
  assign first_byte = (byte_cnt == '0) && (line_cnt == '0);
  assign last_byte  = (byte_cnt == ACT_LAST);

  // In IDLE, stale bytes are flushed until a frame-start beat appears; that beat
  // is held back so it becomes byte 0 of line 0.
  assign s.tready = ~rst & (in_active | ((state == IDLE) & ~s.tuser));
  assign start    = (state == IDLE) & enable & s.tvalid & s.tuser;
  assign cont     = enable & ~err_frame_reg;
  assign err_now  = in_active & s.tvalid &
                    ((s.tlast != last_byte) | (s.tuser != first_byte));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      dout_reg      <= '0;
      href_reg      <= 1'b0;
      vsync_reg     <= 1'b0;
      underrun_reg  <= 1'b0;
      sync_err_reg  <= 1'b0;
      err_frame_reg <= 1'b0;
    end else begin
      href_reg      <= in_active;
      vsync_reg     <= (state == VSYNC);
      dout_reg      <= (in_active && s.tvalid) ? s.tdata : 8'h00;
      underrun_reg  <= in_active && !s.tvalid;
      sync_err_reg  <= err_now;
      err_frame_reg <= (state == IDLE) ? 1'b0 : (err_frame_reg | err_now);
    end
  end

  assign dout     = dout_reg;
  assign href     = href_reg;
  assign vsync    = vsync_reg;
  assign underrun = underrun_reg;
  assign sync_err = sync_err_reg;

endmodule

// File: tb/tb_dvp_transmitter.sv
// Directed bench for dvp_transmitter with a 4x2 active frame and one-line blanking spans.
module tb_dvp_transmitter;

  localparam int HA = 4, HB = 2, VA = 2, VS = 1, VB = 1, VF = 1;

  logic       pclk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] dout;
  logic       href, vsync, underrun, sync_err;

  dvp_transmitter_if s();

  dvp_transmitter #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .s(s),
    .dout(dout), .href(href), .vsync(vsync),
    .underrun(underrun), .sync_err(sync_err)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit       gap;
    bit [7:0] data;
    bit       last;
    bit       user;
  } beat_t;

  beat_t    beat_q[$];
  bit       tr_vs[$], tr_hr[$], tr_un[$], tr_se[$], tr_rdy[$];
  bit [7:0] tr_do[$];
  int       checks = 0;
  int       errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input bit gap, input bit [7:0] d, input bit l, input bit u);
    beat_t b;
    b.gap = gap; b.data = d; b.last = l; b.user = u;
    beat_q.push_back(b);
  endtask

  task automatic clear_trace();
    tr_vs.delete(); tr_hr.delete(); tr_un.delete();
    tr_se.delete(); tr_rdy.delete(); tr_do.delete();
  endtask

  // One pclk cycle: drive the queue head, record outputs and tready, retire on handshake.
  task automatic step();
    @(negedge pclk);
    if (beat_q.size() > 0 && !beat_q[0].gap) begin
      s.tvalid = 1'b1; s.tdata = beat_q[0].data;
      s.tlast  = beat_q[0].last; s.tuser = beat_q[0].user;
    end else begin
      s.tvalid = 1'b0; s.tdata = 8'h00; s.tlast = 1'b0; s.tuser = 1'b0;
    end
    #1;
    tr_vs.push_back(vsync);   tr_hr.push_back(href);   tr_do.push_back(dout);
    tr_un.push_back(underrun); tr_se.push_back(sync_err); tr_rdy.push_back(s.tready);
    if (beat_q.size() > 0 && s.tready) beat_q.delete(0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge pclk);
    rst = 1'b1;
    s.tvalid = 1'b0; s.tuser = 1'b0; s.tlast = 1'b0; s.tdata = 8'h00;
    beat_q.delete();
    clear_trace();
    #1;
    check({tag, "_tready_in_rst"}, 32'(s.tready), 32'd0);
    @(negedge pclk);
    check({tag, "_outs_in_rst"}, 32'({href, vsync, dout, underrun, sync_err}), 32'd0);
    rst = 1'b0;
  endtask

  function automatic int find_t0();
    for (int i = 0; i < tr_vs.size(); i++) if (tr_vs[i]) return i;
    return -1;
  endfunction

  // Frame = 6 vsync, 6 back porch, 2 x (4 href + 2 blank), 6 front porch cycles.
  task automatic check_frame(input string tag, input int t0, input bit [63:0] bytes,
                             input bit [7:0] un_m, input bit [7:0] se_m);
    for (int o = 0; o < 30; o++) begin
      bit e_vs, e_hr, e_un, e_se;
      bit [7:0] e_do;
      int idx;
      e_vs = (o < 6); e_hr = 1'b0; e_do = 8'h00; e_un = 1'b0; e_se = 1'b0;
      if (o >= 12 && o < 24 && ((o - 12) % 6) < 4) begin
        idx  = ((o - 12) / 6) * 4 + (o - 12) % 6;
        e_hr = 1'b1;
        e_do = bytes[idx*8 +: 8];
        e_un = un_m[idx];
        e_se = se_m[idx];
      end
      check($sformatf("%s_o%0d", tag, o),
            32'({tr_rdy[t0+o-1], tr_vs[t0+o], tr_hr[t0+o], tr_do[t0+o], tr_un[t0+o], tr_se[t0+o]}),
            32'({e_hr, e_vs, e_hr, e_do, e_un, e_se}));
    end
  endtask

  task automatic check_idle_after(input string tag, input int t0);
    for (int o = 30; o < 50; o++)
      check($sformatf("%s_idle_o%0d", tag, o),
            32'({tr_rdy[t0+o-1], tr_vs[t0+o], tr_hr[t0+o]}), 32'b100);
  endtask

  initial begin
    int t0;
    bit found;
    rst = 1'b1; enable = 1'b0;
    s.tvalid = 1'b0; s.tdata = 8'h00; s.tlast = 1'b0; s.tuser = 1'b0;

    // A: three stale beats dropped in IDLE, then two back-to-back clean frames
    do_reset("A");
    enable = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
    repeat (2) for (int i = 0; i < 8; i++) push(1'b0, 8'(i), (i == 3 || i == 7), (i == 0));
    repeat (70) step();
    for (int c = 0; c < 3; c++) check($sformatf("A_drop_rdy%0d", c), 32'(tr_rdy[c]), 32'd1);
    check("A_tuser_hold_rdy", 32'(tr_rdy[3]), 32'd0);
    for (int c = 0; c < 4; c++) check($sformatf("A_idle_sync%0d", c), 32'({tr_vs[c], tr_hr[c]}), 32'd0);
    t0 = find_t0();
    check("A_t0", 32'(t0), 32'd5);
    check_frame("A_f1", 5, 64'h0706050403020100, 8'h00, 8'h00);
    check_frame("A_f2", 35, 64'h0706050403020100, 8'h00, 8'h00);
    $display("scenario A clean frames: checks %0d errors %0d", checks, errors);

    // B: missing beat at line 0 byte 2 shifts the stream by one slot
    do_reset("B");
    enable = 1'b1;
    push(1'b0, 8'd0, 1'b0, 1'b1);
    push(1'b0, 8'd1, 1'b0, 1'b0);
    push(1'b1, 8'd0, 1'b0, 1'b0);
    for (int i = 2; i < 8; i++) push(1'b0, 8'(i), (i == 3 || i == 7), 1'b0);
    repeat (56) step();
    t0 = find_t0();
    check("B_t0", 32'(t0), 32'd2);
    check_frame("B_f1", 2, 64'h0605040302000100, 8'b0000_0100, 8'b1001_1000);
    check_idle_after("B", 2);
    $display("scenario B underrun: checks %0d errors %0d", checks, errors);

    // C: early tlast on line 0 byte 2 -> one sync_err, frame completes, back to IDLE
    do_reset("C");
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b0, 8'(i), (i == 2 || i == 3 || i == 7), (i == 0));
    repeat (56) step();
    t0 = find_t0();
    check("C_t0", 32'(t0), 32'd2);
    check_frame("C_f1", 2, 64'h0706050403020100, 8'h00, 8'b0000_0100);
    check_idle_after("C", 2);
    $display("scenario C early tlast: checks %0d errors %0d", checks, errors);

    // F: enable dropped during line 0 -> frame still finishes, then IDLE
    do_reset("F");
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b0, 8'(i), (i == 3 || i == 7), (i == 0));
    for (int i = 0; i < 56; i++) begin
      step();
      if (enable && tr_hr[tr_hr.size()-1]) enable = 1'b0;
    end
    t0 = find_t0();
    check("F_t0", 32'(t0), 32'd2);
    check_frame("F_f1", 2, 64'h0706050403020100, 8'h00, 8'h00);
    check_idle_after("F", 2);
    $display("scenario F enable drop: checks %0d errors %0d", checks, errors);

    // E: asynchronous reset in the middle of an active line
    do_reset("E");
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b0, 8'(8'h10 + i), (i == 3 || i == 7), (i == 0));
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (tr_hr[tr_hr.size()-1]) found = 1'b1;
    end
    check("E_href_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("E_async_clear", 32'({href, vsync, dout, s.tready, underrun, sync_err}), 32'd0);
    @(negedge pclk);
    beat_q.delete();
    enable = 1'b0;
    rst = 1'b0;
    s.tvalid = 1'b1; s.tuser = 1'b0; s.tlast = 1'b0; s.tdata = 8'h55;
    #1;
    check("E_idle_drop_rdy", 32'(s.tready), 32'd1);
    @(negedge pclk);
    s.tuser = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("E_idle_hold%0d", c),
            32'({s.tready, vsync, href, dout, underrun, sync_err}), 32'd0);
      @(negedge pclk);
    end
    s.tvalid = 1'b0; s.tuser = 1'b0;
    $display("scenario E async reset: checks %0d errors %0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
